// File: rtl/vp_scale_ctrl_if.sv
// CPU-side staging register write bus for vp_scale_ctrl.
interface vp_scale_ctrl_if;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_wdata;

    modport master (output cfg_we, cfg_addr, cfg_wdata);
    modport slave  (input  cfg_we, cfg_addr, cfg_wdata);
endinterface

// File: rtl/vp_scale_ctrl.sv
// Crop/scale configuration sequencer: staging registers, commit validation,
// sequential Q4.14 scale divide, frame-synchronous swap, FIFO reset / scaler start.
module vp_scale_ctrl #(
    parameter int H_DISP       = 1280,
    parameter int V_DISP       = 720,
    parameter int COORD_W      = 12,
    parameter int RES_W        = 11,
    parameter int SCALE_BITS   = 18,
    parameter int FIFO_RST_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vp_scale_ctrl_if.slave        cfg,
    input  logic                  vi_vs,
    output logic [COORD_W-1:0]    start_x,
    output logic [COORD_W-1:0]    start_y,
    output logic [COORD_W-1:0]    end_x,
    output logic [COORD_W-1:0]    end_y,
    output logic [RES_W-1:0]      in_x_res,
    output logic [RES_W-1:0]      in_y_res,
    output logic [RES_W-1:0]      out_x_res,
    output logic [RES_W-1:0]      out_y_res,
    output logic [SCALE_BITS-1:0] x_scale,
    output logic [SCALE_BITS-1:0] y_scale,
    output logic                  nearest,
    output logic                  fifo_rst,
    output logic                  scaler_start,
    output logic                  busy,
    output logic                  cfg_err
);
    localparam int FRAC_W = SCALE_BITS - 4;
    localparam int NUM_W  = COORD_W + FRAC_W;
    localparam int DEN_W  = RES_W + 1;
    localparam int CNT_W  = $clog2(NUM_W);
    localparam int RC_W   = $clog2(FIFO_RST_CYC) + 1;
    localparam logic [COORD_W-1:0]    H_MAX     = COORD_W'(H_DISP);
    localparam logic [COORD_W-1:0]    V_MAX     = COORD_W'(V_DISP);
    localparam logic [RES_W-1:0]      H_RES     = RES_W'(H_DISP - 1);
    localparam logic [RES_W-1:0]      V_RES     = RES_W'(V_DISP - 1);
    localparam logic [SCALE_BITS-1:0] SCALE_ONE = SCALE_BITS'(1 << FRAC_W);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV_X, S_DIV_Y, S_WAIT_VS} state_t;
    state_t state_q, state_d;

    logic [COORD_W-1:0]    stg_sx_q, stg_sy_q, stg_ex_q, stg_ey_q;
    logic [RES_W-1:0]      stg_ox_q, stg_oy_q;
    logic                  stg_near_q;
    logic [COORD_W-1:0]    snap_sx_q, snap_sy_q, snap_ex_q, snap_ey_q;
    logic [RES_W-1:0]      snap_ox_q, snap_oy_q;
    logic                  snap_near_q;
    logic [SCALE_BITS-1:0] res_xs_q, res_ys_q;
    logic [NUM_W-1:0]      num_q, num_d;
    logic [DEN_W-1:0]      rem_q, rem_d, den;
    logic [DEN_W:0]        trial;
    logic [CNT_W-1:0]      cnt_q;
    logic [SCALE_BITS-1:0] q_sat;
    logic [COORD_W-1:0]    dx, dy;
    logic [COORD_W-1:0]    act_sx_q, act_sy_q, act_ex_q, act_ey_q;
    logic [RES_W-1:0]      act_ixr_q, act_iyr_q, act_oxr_q, act_oyr_q;
    logic [SCALE_BITS-1:0] act_xs_q, act_ys_q;
    logic                  act_near_q, cfg_err_q;
    logic                  vs_q, vs_prev_q, fifo_rst_q, start_q;
    logic [RC_W-1:0]       rc_q;
    logic                  commit, vs_rise, cfg_ok, div_last, ge;

    assign commit   = cfg.cfg_we && (cfg.cfg_addr == 3'd6) && cfg.cfg_wdata[1];
    assign vs_rise  = vs_q && !vs_prev_q;
    assign cfg_ok   = (snap_ex_q > snap_sx_q) && (snap_ey_q > snap_sy_q) &&
                      (snap_ex_q <= H_MAX) && (snap_ey_q <= V_MAX);
    assign div_last = (cnt_q == CNT_W'(NUM_W - 1));
    assign dx       = snap_ex_q - snap_sx_q;
    assign dy       = snap_ey_q - snap_sy_q;

    // Next-state logic for the commit sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (commit) state_d = S_CHECK;
            S_CHECK:   state_d = cfg_ok ? S_DIV_X : S_IDLE;
            S_DIV_X:   if (div_last) state_d = S_DIV_Y;
            S_DIV_Y:   if (div_last) state_d = S_WAIT_VS;
            S_WAIT_VS: if (vs_rise) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // One restoring-division step; num_q shifts out numerator bits and shifts in quotient bits
    always_comb begin
        den   = {1'b0, (state_q == S_DIV_Y) ? snap_oy_q : snap_ox_q} + DEN_W'(1);
        trial = {rem_q, num_q[NUM_W-1]};
        ge    = (trial >= {1'b0, den});
        rem_d = ge ? DEN_W'(trial - {1'b0, den}) : DEN_W'(trial);
        num_d = {num_q[NUM_W-2:0], ge};
        q_sat = (|num_d[NUM_W-1:SCALE_BITS]) ? '1 : num_d[SCALE_BITS-1:0];
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // CPU staging registers, writable at any time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_sx_q <= '0;    stg_sy_q <= '0;
            stg_ex_q <= H_MAX; stg_ey_q <= V_MAX;
            stg_ox_q <= H_RES; stg_oy_q <= V_RES;
            stg_near_q <= 1'b1;
        end else if (cfg.cfg_we) begin
            case (cfg.cfg_addr)
                3'd0:    stg_sx_q   <= cfg.cfg_wdata[COORD_W-1:0];
                3'd1:    stg_sy_q   <= cfg.cfg_wdata[COORD_W-1:0];
                3'd2:    stg_ex_q   <= cfg.cfg_wdata[COORD_W-1:0];
                3'd3:    stg_ey_q   <= cfg.cfg_wdata[COORD_W-1:0];
                3'd4:    stg_ox_q   <= cfg.cfg_wdata[RES_W-1:0];
                3'd5:    stg_oy_q   <= cfg.cfg_wdata[RES_W-1:0];
                3'd6:    stg_near_q <= cfg.cfg_wdata[0];
                default: ;
            endcase
        end
    end

    // Commit snapshot, validation result and the x-then-y divide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_sx_q <= '0;    snap_sy_q <= '0;
            snap_ex_q <= H_MAX; snap_ey_q <= V_MAX;
            snap_ox_q <= H_RES; snap_oy_q <= V_RES;
            snap_near_q <= 1'b1;
            res_xs_q <= SCALE_ONE; res_ys_q <= SCALE_ONE;
            num_q <= '0; rem_q <= '0; cnt_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (commit) begin
                    snap_sx_q <= stg_sx_q; snap_sy_q <= stg_sy_q;
                    snap_ex_q <= stg_ex_q; snap_ey_q <= stg_ey_q;
                    snap_ox_q <= stg_ox_q; snap_oy_q <= stg_oy_q;
                    snap_near_q <= cfg.cfg_wdata[0];
                end
                S_CHECK: begin
                    cfg_err_q <= !cfg_ok;
                    num_q <= {dx, {FRAC_W{1'b0}}};
                    rem_q <= '0;
                    cnt_q <= '0;
                end
                S_DIV_X, S_DIV_Y: begin
                    if (div_last) begin
                        if (state_q == S_DIV_X) res_xs_q <= q_sat;
                        else                    res_ys_q <= q_sat;
                        num_q <= {dy, {FRAC_W{1'b0}}};
                        rem_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        num_q <= num_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Active set: swapped as a whole on the frame edge that finds a finished commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_sx_q <= '0;    act_sy_q <= '0;
            act_ex_q <= H_MAX; act_ey_q <= V_MAX;
            act_ixr_q <= H_RES; act_iyr_q <= V_RES;
            act_oxr_q <= H_RES; act_oyr_q <= V_RES;
            act_xs_q <= SCALE_ONE; act_ys_q <= SCALE_ONE;
            act_near_q <= 1'b1;
        end else if ((state_q == S_WAIT_VS) && vs_rise) begin
            act_sx_q <= snap_sx_q; act_sy_q <= snap_sy_q;
            act_ex_q <= snap_ex_q; act_ey_q <= snap_ey_q;
            act_ixr_q <= RES_W'(dx - COORD_W'(1));
            act_iyr_q <= RES_W'(dy - COORD_W'(1));
            act_oxr_q <= snap_ox_q; act_oyr_q <= snap_oy_q;
            act_xs_q <= res_xs_q; act_ys_q <= res_ys_q;
            act_near_q <= snap_near_q;
        end
    end

    // Frame edge detect, FIFO reset window (restarted by a new edge) and scaler start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= 1'b0; vs_prev_q <= 1'b0;
            fifo_rst_q <= 1'b0; start_q <= 1'b0; rc_q <= '0;
        end else begin
            vs_q      <= vi_vs;
            vs_prev_q <= vs_q;
            start_q   <= 1'b0;
            if (vs_rise) begin
                fifo_rst_q <= 1'b1;
                rc_q       <= '0;
            end else if (fifo_rst_q) begin
                if (rc_q == RC_W'(FIFO_RST_CYC - 1)) begin
                    fifo_rst_q <= 1'b0;
                    start_q    <= 1'b1;
                end else begin
                    rc_q <= rc_q + RC_W'(1);
                end
            end
        end
    end

    assign start_x   = act_sx_q;  assign start_y   = act_sy_q;
    assign end_x     = act_ex_q;  assign end_y     = act_ey_q;
    assign in_x_res  = act_ixr_q; assign in_y_res  = act_iyr_q;
    assign out_x_res = act_oxr_q; assign out_y_res = act_oyr_q;
    assign x_scale   = act_xs_q;  assign y_scale   = act_ys_q;
    assign nearest   = act_near_q;
    assign fifo_rst  = fifo_rst_q;
    assign scaler_start = start_q;
    assign busy      = (state_q != S_IDLE);
    assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_vp_scale_ctrl.sv
// Scoreboard bench for vp_scale_ctrl: stimulus pushes expected frame starts, a monitor checks them.
module tb_vp_scale_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, vi_vs;
    logic [11:0] start_x, start_y, end_x, end_y;
    logic [10:0] in_x_res, in_y_res, out_x_res, out_y_res;
    logic [17:0] x_scale, y_scale;
    logic        nearest, fifo_rst, scaler_start, busy, cfg_err;

    vp_scale_ctrl_if cfg_bus ();

    vp_scale_ctrl #(.H_DISP(1280), .V_DISP(720), .COORD_W(12), .RES_W(11),
                    .SCALE_BITS(18), .FIFO_RST_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg(cfg_bus), .vi_vs(vi_vs),
        .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y),
        .in_x_res(in_x_res), .in_y_res(in_y_res), .out_x_res(out_x_res), .out_y_res(out_y_res),
        .x_scale(x_scale), .y_scale(y_scale), .nearest(nearest), .fifo_rst(fifo_rst),
        .scaler_start(scaler_start), .busy(busy), .cfg_err(cfg_err));

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        int sx, sy, ex, ey, ixr, iyr, oxr, oyr, xs, ys, nr;
    } frame_t;

    frame_t      exp_q[$];
    frame_t      cur, pend;
    bit          pend_valid, m_busy, m_err;
    int unsigned pend_ready;
    int          stg [0:6];
    bit          fr_exp [0:29999];
    int unsigned n_cmp = 0, n_bad = 0;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic frame_t reset_frame();
        frame_t f;
        f.at = 0; f.sx = 0; f.sy = 0; f.ex = 1280; f.ey = 720;
        f.ixr = 1279; f.iyr = 719; f.oxr = 1279; f.oyr = 719;
        f.xs = 16384; f.ys = 16384; f.nr = 1;
        return f;
    endfunction

    // Ratio of crop span to output size in Q4.14, truncated then clamped to 18 bits
    function automatic int scale(int span, int ores);
        longint q;
        q = (longint'(span) * 16384) / (ores + 1);
        return (q > 262143) ? 262143 : int'(q);
    endfunction

    task automatic model_reset();
        cur = reset_frame();
        stg[0] = 0; stg[1] = 0; stg[2] = 1280; stg[3] = 720;
        stg[4] = 1279; stg[5] = 719; stg[6] = 1;
        pend_valid = 0; m_busy = 0; m_err = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_commit(int unsigned e);
        bit ok;
        ok = (stg[2] > stg[0]) && (stg[3] > stg[1]) && (stg[2] <= 1280) && (stg[3] <= 720);
        if (ok) begin
            pend.sx = stg[0]; pend.sy = stg[1]; pend.ex = stg[2]; pend.ey = stg[3];
            pend.ixr = stg[2] - stg[0] - 1; pend.iyr = stg[3] - stg[1] - 1;
            pend.oxr = stg[4]; pend.oyr = stg[5];
            pend.xs = scale(stg[2] - stg[0], stg[4]);
            pend.ys = scale(stg[3] - stg[1], stg[5]);
            pend.nr = stg[6];
            pend_valid = 1; m_busy = 1; pend_ready = e + 53; m_err = 0;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic wr(int a, int d);
        logic [11:0] dv;
        dv = d[11:0];
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = a[2:0]; cfg_bus.cfg_wdata = dv;
        tick();
        cfg_bus.cfg_we = 1'b0;
        if (a < 6) stg[a] = d;
        else begin
            stg[6] = d & 1;
            if (((d >> 1) & 1) == 1 && !m_busy) model_commit(cyc);
        end
    endtask

    task automatic set_cfg(int sx, int sy, int ex, int ey, int ox, int oy);
        wr(0, sx); wr(1, sy); wr(2, ex); wr(3, ey); wr(4, ox); wr(5, oy);
    endtask

    task automatic commit(int nr, output int unsigned e);
        wr(6, 2 | nr);
        e = cyc;
    endtask

    // One-cycle vs pulse; the frame edge is the clock edge that samples it
    task automatic vs_pulse();
        int unsigned s;
        frame_t r;
        vi_vs = 1'b1;
        tick();
        vi_vs = 1'b0;
        s = cyc;
        if (pend_valid && s >= pend_ready) begin
            cur = pend; pend_valid = 0; m_busy = 0;
        end
        r = cur;
        r.at = s + 5;
        if (exp_q.size() > 0 && exp_q[$].at > s) void'(exp_q.pop_back());
        exp_q.push_back(r);
        for (int k = 1; k <= 4; k++) if (s + k < 30000) fr_exp[s + k] = 1'b1;
    endtask

    task automatic vs_at(int unsigned s);
        while (cyc + 1 < s) tick();
        vs_pulse();
    endtask

    task automatic chk_act();
        chk("start_x", start_x, cur.sx);     chk("start_y", start_y, cur.sy);
        chk("end_x", end_x, cur.ex);         chk("end_y", end_y, cur.ey);
        chk("in_x_res", in_x_res, cur.ixr);  chk("in_y_res", in_y_res, cur.iyr);
        chk("out_x_res", out_x_res, cur.oxr); chk("out_y_res", out_y_res, cur.oyr);
        chk("x_scale", x_scale, cur.xs);     chk("y_scale", y_scale, cur.ys);
        chk("nearest", nearest, cur.nr);
    endtask

    // Monitor: FIFO reset window every cycle, and each scaler start against the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (cyc < 30000) chk("fifo_rst", fifo_rst, fr_exp[cyc]);
            if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL start_missing: got none expected pulse at cycle %0d", exp_q[0].at);
                void'(exp_q.pop_front());
            end
            if (scaler_start) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL start_unexpected: got pulse at cycle %0d expected none", cyc);
                end else begin
                    frame_t r;
                    r = exp_q.pop_front();
                    chk("start_cycle", cyc, r.at);
                    chk("f_start_x", start_x, r.sx);  chk("f_end_x", end_x, r.ex);
                    chk("f_start_y", start_y, r.sy);  chk("f_end_y", end_y, r.ey);
                    chk("f_in_x_res", in_x_res, r.ixr); chk("f_in_y_res", in_y_res, r.iyr);
                    chk("f_out_x_res", out_x_res, r.oxr); chk("f_out_y_res", out_y_res, r.oyr);
                    chk("f_x_scale", x_scale, r.xs);  chk("f_y_scale", y_scale, r.ys);
                    chk("f_nearest", nearest, r.nr);
                end
            end
        end
    end

    initial begin
        int unsigned e;
        rst_n = 1'b0; vi_vs = 1'b0;
        cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_wdata = '0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state and a frame with the default set
        chk_act();
        chk("busy_reset", busy, 0); chk("cfg_err_reset", cfg_err, 0);
        chk("start_reset", scaler_start, 0);
        vs_pulse();
        repeat (8) tick();

        // Half-size crop; a frame edge one cycle before the divide ends must not apply it
        set_cfg(320, 180, 960, 540, 1279, 719);
        commit(1, e);
        chk("busy_commit", busy, 1);
        vs_at(e + 52);
        repeat (6) tick();
        chk_act();
        chk("busy_wait_vs", busy, 1);
        vs_at(cyc + 3);
        repeat (8) tick();
        chk_act();
        chk("x_scale_half", x_scale, 'h2000); chk("y_scale_half", y_scale, 'h2000);
        chk("in_x_res_639", in_x_res, 639);

        // Full frame to half output, applied on the first possible edge
        set_cfg(0, 0, 1280, 720, 639, 359);
        commit(0, e);
        vs_at(e + 53);
        repeat (8) tick();
        chk_act();
        chk("x_scale_dbl", x_scale, 'h8000); chk("y_scale_dbl", y_scale, 'h8000);
        chk("busy_done", busy, 0);

        // Empty window rejected, then a valid commit clears the error
        wr(0, 300); wr(2, 300);
        commit(1, e);
        tick();
        chk("cfg_err_set", cfg_err, 1); chk("busy_reject", busy, 0);
        chk_act();
        wr(2, 900);
        commit(1, e);
        tick();
        chk("cfg_err_clear", cfg_err, 0);
        vs_at(e + 53);
        repeat (8) tick();
        chk_act();

        // Two edges two cycles apart: FIFO reset extends, one start
        vs_pulse(); tick(); vs_pulse();
        repeat (10) tick();

        // Commit while busy is dropped and staging writes do not reach the in-flight set
        set_cfg(100, 50, 1100, 650, 999, 299);
        commit(1, e);
        repeat (19) tick();
        wr(0, 200);
        wr(6, 2);
        vs_at(e + 53);
        repeat (8) tick();
        chk_act();

        // Reset during the x divide
        commit(0, e);
        repeat (11) tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_act();
        chk("busy_rst", busy, 0); chk("cfg_err_rst", cfg_err, 0);
        chk("fifo_rst_rst", fifo_rst, 0); chk("start_rst", scaler_start, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        vs_pulse();
        repeat (8) tick();
        chk_act();

        // Random windows, including invalid ones and saturating ratios
        for (int i = 0; i < 10; i++) begin
            int sx, sy, ex, ey, ox, oy;
            sx = $urandom_range(0, 1279); ex = $urandom_range(0, 1400);
            sy = $urandom_range(0, 719);  ey = $urandom_range(0, 800);
            ox = (i % 3 == 0) ? $urandom_range(0, 40) : $urandom_range(0, 2047);
            oy = (i % 3 == 0) ? $urandom_range(0, 20) : $urandom_range(0, 2047);
            set_cfg(sx, sy, ex, ey, ox, oy);
            commit($urandom_range(0, 1), e);
            tick();
            chk("cfg_err_rand", cfg_err, m_err);
            if (!m_err) vs_at(e + 53 + $urandom_range(0, 4));
            else vs_pulse();
            repeat (8) tick();
            chk_act();
        end

        repeat (10) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
